mem_wb_stage: RTL and testbench

MEM stage of the 5-stage MIPS pipeline, fused with the MEM/WB pipeline register. It consumes the EXE/MEM register outputs, performs data-memory load/store, and selects the write-back value. It registers the write-back bundle for the WB stage, which feeds the register file and the WB-to-ID forwarding path. It also exports combinational MEM-stage information to the hazard/forwarding unit.

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_wb_stage_if.sv | 37 +++
 rtl/dmem.sv | 28 ++
 rtl/mem_wb_stage.sv | 120 ++++++++++++
 tb/tb_mem_wb_stage.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared constants for the MEM/WB stage: write-back select encodings and load/store opcodes.
package mem_pkg;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'b00,
        WB_SEL_MEM = 2'b01,
        WB_SEL_NPC = 2'b10,
        WB_SEL_RSV = 2'b11
    } wb_sel_e;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2b;

endpackage

// File: rtl/mem_wb_stage_if.sv
// EXE/MEM inputs, MEM/WB register outputs and hazard-unit taps of the MEM stage.
interface mem_wb_stage_if #(
    parameter int WB_SEL_W = 2
) ();

    logic [31:0]         npc_EXE_MEM;
    logic [31:0]         c_EXE_MEM;
    logic [31:0]         b_EXE_MEM;
    logic [4:0]          num_write_EXE_MEM;
    logic                mem_write_EXE_MEM;
    logic [WB_SEL_W-1:0] s_data_write_EXE_MEM;
    logic                reg_write_EXE_MEM;
    logic [31:0]         ins_EXE_MEM;

    logic [31:0]         wdata_MEM_WB;
    logic [4:0]          num_write_MEM_WB;
    logic                reg_write_MEM_WB;
    logic [31:0]         ins_MEM_WB;
    logic [31:0]         fwd_data_MEM;
    logic                load_in_MEM;
    logic                misalign_err;

    modport master (
        output npc_EXE_MEM, c_EXE_MEM, b_EXE_MEM, num_write_EXE_MEM,
        output mem_write_EXE_MEM, s_data_write_EXE_MEM, reg_write_EXE_MEM, ins_EXE_MEM,
        input  wdata_MEM_WB, num_write_MEM_WB, reg_write_MEM_WB, ins_MEM_WB,
        input  fwd_data_MEM, load_in_MEM, misalign_err
    );

    modport slave (
        input  npc_EXE_MEM, c_EXE_MEM, b_EXE_MEM, num_write_EXE_MEM,
        input  mem_write_EXE_MEM, s_data_write_EXE_MEM, reg_write_EXE_MEM, ins_EXE_MEM,
        output wdata_MEM_WB, num_write_MEM_WB, reg_write_MEM_WB, ins_MEM_WB,
        output fwd_data_MEM, load_in_MEM, misalign_err
    );

endinterface

// File: rtl/dmem.sv
// Data memory: 2**ADDR_W x 32 words, byte-enable synchronous write, asynchronous read.
module dmem #(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              i_we,
    input  logic [3:0]        i_be,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [2**ADDR_W];

    // No reset: contents survive a pipeline reset.
    always_ff @(posedge clock) begin
        if (i_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage fused with the MEM/WB register; optional sub-word loads/stores under BYTE_ACCESS_EN.
module mem_wb_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int WB_SEL_W = 2
) (
    input  logic          clock,
    input  logic          reset,
    mem_wb_stage_if.slave bus
);

    logic [ADDR_W-1:0]   w_addr;
    logic [1:0]          w_lane;
    logic [WB_SEL_W-1:0] w_sel;
    logic                w_is_load;
    logic                w_byte_ld;
    logic                w_byte_st;
    logic                w_st_misalign;
    logic                w_ld_misalign;
    logic                w_we;
    logic [3:0]          w_be;
    logic [31:0]         w_wdata;
    logic [31:0]         w_rdata;
    logic [31:0]         w_load;
    logic [31:0]         w_wb;

    logic [31:0]         r_wdata;
    logic [4:0]          r_num;
    logic                r_reg_write;
    logic [31:0]         r_ins;
    logic                r_misalign;

    assign w_addr    = bus.c_EXE_MEM[ADDR_W+1:2];
    assign w_lane    = bus.c_EXE_MEM[1:0];
    assign w_sel     = bus.s_data_write_EXE_MEM;
    assign w_is_load = bus.reg_write_EXE_MEM & (w_sel == WB_SEL_MEM);

`ifdef BYTE_ACCESS_EN
    logic [5:0] w_op;
    logic [7:0] w_rbyte;

    assign w_op      = bus.ins_EXE_MEM[31:26];
    assign w_byte_ld = (w_op == OP_LB) || (w_op == OP_LBU);
    assign w_byte_st = (w_op == OP_SB);
    assign w_rbyte   = w_rdata[{w_lane, 3'b000} +: 8];

    always_comb begin
        w_be    = 4'hF;
        w_wdata = bus.b_EXE_MEM;
        w_load  = w_rdata;
        if (w_byte_st) begin
            w_be    = 4'b0001 << w_lane;
            w_wdata = {4{bus.b_EXE_MEM[7:0]}};
        end
        if (w_op == OP_LB) begin
            w_load = {{24{w_rbyte[7]}}, w_rbyte};
        end else if (w_op == OP_LBU) begin
            w_load = {24'h0, w_rbyte};
        end
    end
`else
    assign w_byte_ld = 1'b0;
    assign w_byte_st = 1'b0;
    assign w_be      = 4'hF;
    assign w_wdata   = bus.b_EXE_MEM;
    assign w_load    = w_rdata;
`endif

    // Word accesses must be aligned; misaligned loads still return the aligned word.
    assign w_st_misalign = bus.mem_write_EXE_MEM & ~w_byte_st & (w_lane != 2'b00);
    assign w_ld_misalign = w_is_load & ~w_byte_ld & (w_lane != 2'b00);
    assign w_we          = bus.mem_write_EXE_MEM & ~reset & ~w_st_misalign;

    dmem #(.ADDR_W(ADDR_W)) u_dmem (
        .clock   (clock),
        .i_we    (w_we),
        .i_be    (w_be),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_wb = '0;
        case (w_sel)
            WB_SEL_ALU: w_wb = bus.c_EXE_MEM;
            WB_SEL_MEM: w_wb = w_load;
            WB_SEL_NPC: w_wb = bus.npc_EXE_MEM;
            default:    w_wb = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wdata     <= '0;
            r_num       <= '0;
            r_reg_write <= 1'b0;
            r_ins       <= '0;
            r_misalign  <= 1'b0;
        end else begin
            r_wdata     <= w_wb;
            r_num       <= bus.num_write_EXE_MEM;
            r_reg_write <= bus.reg_write_EXE_MEM & (bus.num_write_EXE_MEM != 5'd0);
            r_ins       <= bus.ins_EXE_MEM;
            if (w_st_misalign | w_ld_misalign) begin
                r_misalign <= 1'b1;
            end
        end
    end

    assign bus.wdata_MEM_WB     = r_wdata;
    assign bus.num_write_MEM_WB = r_num;
    assign bus.reg_write_MEM_WB = r_reg_write;
    assign bus.ins_MEM_WB       = r_ins;
    assign bus.misalign_err     = r_misalign;
    assign bus.fwd_data_MEM     = w_wb;
    assign bus.load_in_MEM      = w_is_load;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized traffic against a word-array model.
module tb_mem_wb_stage;
    import mem_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] ref_mem [DEPTH];
    logic        ref_err;

    mem_wb_stage_if #(.WB_SEL_W(2)) bus ();

    mem_wb_stage #(.ADDR_W(ADDR_W), .WB_SEL_W(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] npc, input logic [31:0] c, input logic [31:0] b,
                         input logic [4:0] num, input logic mw, input logic [1:0] sel,
                         input logic rw, input logic [31:0] ins);
        bus.npc_EXE_MEM          = npc;
        bus.c_EXE_MEM            = c;
        bus.b_EXE_MEM            = b;
        bus.num_write_EXE_MEM    = num;
        bus.mem_write_EXE_MEM    = mw;
        bus.s_data_write_EXE_MEM = sel;
        bus.reg_write_EXE_MEM    = rw;
        bus.ins_EXE_MEM          = ins;
    endtask

    task automatic bubble;
        drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 1'b0, 32'h0);
    endtask

    function automatic logic [7:0] ref_idx(input logic [31:0] a);
        return 8'((a / 32'd4) % 32'(DEPTH));
    endfunction

    function automatic bit ref_byte_ld(input logic [31:0] ins);
`ifdef BYTE_ACCESS_EN
        return (ins >> 26) == 32'(OP_LB) || (ins >> 26) == 32'(OP_LBU);
`else
        return (ins & 32'h0) != 32'h0;
`endif
    endfunction

    function automatic bit ref_byte_st(input logic [31:0] ins);
`ifdef BYTE_ACCESS_EN
        return (ins >> 26) == 32'(OP_SB);
`else
        return (ins & 32'h0) != 32'h0;
`endif
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] c, input logic [31:0] ins);
        logic [31:0] w;
        w = ref_mem[ref_idx(c)];
`ifdef BYTE_ACCESS_EN
        begin
            logic [31:0] bt;
            bt = (w >> (8 * (c % 4))) & 32'hFF;
            if ((ins >> 26) == 32'(OP_LB))  return (bt >= 32'h80) ? (32'hFFFFFF00 | bt) : bt;
            if ((ins >> 26) == 32'(OP_LBU)) return bt;
        end
`endif
        return w;
    endfunction

    function automatic logic [31:0] ref_wb(input logic [1:0] sel, input logic [31:0] c,
                                           input logic [31:0] npc, input logic [31:0] ins);
        case (sel)
            2'd0:    return c;
            2'd1:    return ref_load(c, ins);
            2'd2:    return npc;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit ref_mis(input logic [31:0] c, input logic mw, input logic [1:0] sel,
                                   input logic rw, input logic [31:0] ins);
        bit st_bad, ld_bad;
        st_bad = mw && !ref_byte_st(ins) && (c % 4 != 0);
        ld_bad = rw && sel == 2'd1 && !ref_byte_ld(ins) && (c % 4 != 0);
        return st_bad || ld_bad;
    endfunction

    task automatic ref_commit(input logic [31:0] c, input logic [31:0] b, input logic mw,
                              input logic [31:0] ins);
        logic [7:0]  i;
        logic [31:0] sh;
        i = ref_idx(c);
        if (mw && ref_byte_st(ins)) begin
            sh = 8 * (c % 4);
            ref_mem[i] = (ref_mem[i] & ~(32'hFF << sh)) | ((b & 32'hFF) << sh);
        end else if (mw && (c % 4 == 0)) begin
            ref_mem[i] = b;
        end
    endtask

    task automatic preload;
        logic [31:0] v;
        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            drive(32'h0, 32'(i * 4), v, 5'd0, 1'b1, 2'd0, 1'b0, {OP_SW, 26'h0});
            tick;
            ref_mem[i] = v;
        end
        bubble;
    endtask

    task automatic test_reset;
        logic [31:0] old;
        old = ref_mem[4];
        reset = 1'b1;
        drive(32'h44, 32'h10, 32'hCAFEF00D, 5'd7, 1'b1, 2'd0, 1'b1, {OP_SW, 26'h0});
        tick;
        checks++; if (bus.wdata_MEM_WB !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected %h", bus.wdata_MEM_WB, 32'h0); end
        checks++; if (bus.num_write_MEM_WB !== 5'd0) begin errors++; $display("FAIL reset_num: got %0d expected 0", bus.num_write_MEM_WB); end
        checks++; if (bus.reg_write_MEM_WB !== 1'b0) begin errors++; $display("FAIL reset_rw: got %b expected 0", bus.reg_write_MEM_WB); end
        checks++; if (bus.ins_MEM_WB !== 32'h0) begin errors++; $display("FAIL reset_ins: got %h expected 0", bus.ins_MEM_WB); end
        checks++; if (bus.misalign_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.misalign_err); end
        reset = 1'b0;
        drive(32'h48, 32'h10, 32'h0, 5'd3, 1'b0, 2'd1, 1'b1, {OP_LW, 26'h0});
        #1;
        checks++; if (bus.fwd_data_MEM !== old) begin errors++; $display("FAIL reset_store_blocked: got %h expected %h", bus.fwd_data_MEM, old); end
        tick;
        checks++; if (bus.wdata_MEM_WB !== old) begin errors++; $display("FAIL reset_load_wb: got %h expected %h", bus.wdata_MEM_WB, old); end
        bubble;
    endtask

    task automatic test_back_to_back;
        logic [31:0] a, v;
        for (int k = 0; k < 12; k++) begin
            a = (k == 0) ? 32'h10 : {$urandom_range(0, 32'hFFFF), 2'b00};
            v = (k == 0) ? 32'hDEADBEEF : $urandom;
            drive(32'h0, a, v, 5'd0, 1'b1, 2'd0, 1'b0, {OP_SW, 26'h0});
            tick;
            ref_commit(a, v, 1'b1, {OP_SW, 26'h0});
            drive(32'h0, a, 32'h0, 5'd5, 1'b0, 2'd1, 1'b1, {OP_LW, 26'h0});
            #1;
            checks++; if (bus.fwd_data_MEM !== v) begin errors++; $display("FAIL b2b_fwd: got %h expected %h", bus.fwd_data_MEM, v); end
            checks++; if (bus.load_in_MEM !== 1'b1) begin errors++; $display("FAIL b2b_load_in: got %b expected 1", bus.load_in_MEM); end
            tick;
            checks++; if (bus.wdata_MEM_WB !== v) begin errors++; $display("FAIL b2b_wdata: got %h expected %h", bus.wdata_MEM_WB, v); end
            checks++; if (bus.num_write_MEM_WB !== 5'd5) begin errors++; $display("FAIL b2b_num: got %0d expected 5", bus.num_write_MEM_WB); end
            checks++; if (bus.reg_write_MEM_WB !== 1'b1) begin errors++; $display("FAIL b2b_rw: got %b expected 1", bus.reg_write_MEM_WB); end
        end
        bubble;
    endtask

    task automatic test_select;
        logic [1:0]  sel;
        logic [31:0] c, npc, exp;
        for (int k = 0; k < 9; k++) begin
            sel = (k % 3 == 0) ? 2'd0 : (k % 3 == 1) ? 2'd2 : 2'd3;
            c   = (k < 3) ? 32'h1234 : $urandom;
            npc = (k < 3) ? 32'h40 : $urandom;
            exp = (sel == 2'd0) ? c : (sel == 2'd2) ? npc : 32'h0;
            drive(npc, c, $urandom, 5'(k + 1), 1'b0, sel, 1'b1, $urandom);
            #1;
            checks++; if (bus.fwd_data_MEM !== exp) begin errors++; $display("FAIL sel%0d_fwd: got %h expected %h", sel, bus.fwd_data_MEM, exp); end
            checks++; if (bus.load_in_MEM !== 1'b0) begin errors++; $display("FAIL sel%0d_load_in: got %b expected 0", sel, bus.load_in_MEM); end
            tick;
            checks++; if (bus.wdata_MEM_WB !== exp) begin errors++; $display("FAIL sel%0d_wdata: got %h expected %h", sel, bus.wdata_MEM_WB, exp); end
            checks++; if (bus.num_write_MEM_WB !== 5'(k + 1)) begin errors++; $display("FAIL sel_num: got %0d expected %0d", bus.num_write_MEM_WB, k + 1); end
        end
        bubble;
    endtask

    task automatic test_zero_alias;
        logic [31:0] v;
        drive(32'h44, 32'h55, 32'h0, 5'd0, 1'b0, 2'd0, 1'b1, 32'h0);
        tick;
        checks++; if (bus.reg_write_MEM_WB !== 1'b0) begin errors++; $display("FAIL zero_reg_rw: got %b expected 0", bus.reg_write_MEM_WB); end
        checks++; if (bus.wdata_MEM_WB !== 32'h55) begin errors++; $display("FAIL zero_reg_wdata: got %h expected %h", bus.wdata_MEM_WB, 32'h55); end
        v = $urandom;
        drive(32'h0, 32'h400, v, 5'd0, 1'b1, 2'd0, 1'b0, {OP_SW, 26'h0});
        tick;
        ref_commit(32'h400, v, 1'b1, {OP_SW, 26'h0});
        drive(32'h0, 32'h0, 32'h0, 5'd6, 1'b0, 2'd1, 1'b1, {OP_LW, 26'h0});
        #1;
        checks++; if (bus.fwd_data_MEM !== v) begin errors++; $display("FAIL alias_fwd: got %h expected %h", bus.fwd_data_MEM, v); end
        tick;
        checks++; if (bus.wdata_MEM_WB !== v) begin errors++; $display("FAIL alias_wdata: got %h expected %h", bus.wdata_MEM_WB, v); end
        bubble;
    endtask

`ifdef BYTE_ACCESS_EN
    task automatic test_byte;
        logic [5:0]  ops  [3];
        logic [31:0] exps [3];
        logic [31:0] addr [3];
        ops[0] = OP_LB;  exps[0] = 32'hFFFFFF80; addr[0] = 32'h21;
        ops[1] = OP_LBU; exps[1] = 32'h00000080; addr[1] = 32'h21;
        ops[2] = OP_LW;  exps[2] = 32'h00008000; addr[2] = 32'h20;
        drive(32'h0, 32'h20, 32'h0, 5'd0, 1'b1, 2'd0, 1'b0, {OP_SW, 26'h0});
        tick;
        ref_commit(32'h20, 32'h0, 1'b1, {OP_SW, 26'h0});
        drive(32'h0, 32'h21, 32'h80, 5'd0, 1'b1, 2'd0, 1'b0, {OP_SB, 26'h0});
        tick;
        ref_commit(32'h21, 32'h80, 1'b1, {OP_SB, 26'h0});
        for (int k = 0; k < 3; k++) begin
            drive(32'h0, addr[k], 32'h0, 5'd9, 1'b0, 2'd1, 1'b1, {ops[k], 26'h0});
            #1;
            checks++; if (bus.fwd_data_MEM !== exps[k]) begin errors++; $display("FAIL byte%0d_fwd: got %h expected %h", k, bus.fwd_data_MEM, exps[k]); end
            tick;
            checks++; if (bus.wdata_MEM_WB !== exps[k]) begin errors++; $display("FAIL byte%0d_wdata: got %h expected %h", k, bus.wdata_MEM_WB, exps[k]); end
        end
        checks++; if (bus.misalign_err !== 1'b0) begin errors++; $display("FAIL byte_no_misalign: got %b expected 0", bus.misalign_err); end
        bubble;
    endtask
`endif

    task automatic test_misalign;
        logic [31:0] old;
        old = ref_mem[4];
        checks++; if (bus.misalign_err !== 1'b0) begin errors++; $display("FAIL mis_initial: got %b expected 0", bus.misalign_err); end
        drive(32'h0, 32'h13, 32'h11111111, 5'd0, 1'b1, 2'd0, 1'b0, {OP_SW, 26'h0});
        tick;
        checks++; if (bus.misalign_err !== 1'b1) begin errors++; $display("FAIL mis_store_flag: got %b expected 1", bus.misalign_err); end
        drive(32'h0, 32'h10, 32'h0, 5'd2, 1'b0, 2'd1, 1'b1, {OP_LW, 26'h0});
        #1;
        checks++; if (bus.fwd_data_MEM !== old) begin errors++; $display("FAIL mis_store_suppressed: got %h expected %h", bus.fwd_data_MEM, old); end
        bubble;
        repeat (3) tick;
        checks++; if (bus.misalign_err !== 1'b1) begin errors++; $display("FAIL mis_sticky: got %b expected 1", bus.misalign_err); end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checks++; if (bus.misalign_err !== 1'b0) begin errors++; $display("FAIL mis_cleared: got %b expected 0", bus.misalign_err); end
        drive(32'h0, 32'h22, 32'h0, 5'd4, 1'b0, 2'd1, 1'b1, {OP_LW, 26'h0});
        #1;
        checks++; if (bus.fwd_data_MEM !== ref_mem[8]) begin errors++; $display("FAIL mis_load_aligned: got %h expected %h", bus.fwd_data_MEM, ref_mem[8]); end
        tick;
        checks++; if (bus.misalign_err !== 1'b1) begin errors++; $display("FAIL mis_load_flag: got %b expected 1", bus.misalign_err); end
        checks++; if (bus.wdata_MEM_WB !== ref_mem[8]) begin errors++; $display("FAIL mis_load_wdata: got %h expected %h", bus.wdata_MEM_WB, ref_mem[8]); end
        bubble;
        reset = 1'b1;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_random;
        ref_err = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] c, b, npc, ins, exp;
            logic [1:0]  sel;
            logic [4:0]  num;
            logic        rw, mw, rst, exp_ld;
            rst = ($urandom_range(0, 31) == 0);
            c   = $urandom;
            if ($urandom_range(0, 3) != 0) c[1:0] = 2'b00;
            b   = $urandom;
            npc = $urandom;
            sel = 2'($urandom_range(0, 3));
            rw  = 1'($urandom_range(0, 1));
            num = 5'($urandom_range(0, 31));
            mw  = ($urandom_range(0, 3) == 0);
            ins = $urandom;
`ifdef BYTE_ACCESS_EN
            case ($urandom_range(0, 5))
                0: ins[31:26] = OP_LB;
                1: ins[31:26] = OP_LBU;
                2: ins[31:26] = OP_SB;
                3: ins[31:26] = OP_LW;
                4: ins[31:26] = OP_SW;
                default: ;
            endcase
`endif
            reset = rst;
            drive(npc, c, b, num, mw, sel, rw, ins);
            #1;
            exp    = ref_wb(sel, c, npc, ins);
            exp_ld = rw && sel == 2'd1;
            checks++; if (bus.fwd_data_MEM !== exp) begin errors++; $display("FAIL rnd_fwd[%0d]: got %h expected %h", n, bus.fwd_data_MEM, exp); end
            checks++; if (bus.load_in_MEM !== exp_ld) begin errors++; $display("FAIL rnd_load_in[%0d]: got %b expected %b", n, bus.load_in_MEM, exp_ld); end
            tick;
            if (rst) begin
                ref_err = 1'b0;
                checks++; if (bus.wdata_MEM_WB !== 32'h0 || bus.reg_write_MEM_WB !== 1'b0 || bus.ins_MEM_WB !== 32'h0 || bus.num_write_MEM_WB !== 5'd0)
                    begin errors++; $display("FAIL rnd_reset[%0d]: got wdata %h rw %b ins %h num %0d expected all zero", n, bus.wdata_MEM_WB, bus.reg_write_MEM_WB, bus.ins_MEM_WB, bus.num_write_MEM_WB); end
            end else begin
                if (ref_mis(c, mw, sel, rw, ins)) ref_err = 1'b1;
                ref_commit(c, b, mw, ins);
                checks++; if (bus.wdata_MEM_WB !== exp) begin errors++; $display("FAIL rnd_wdata[%0d]: got %h expected %h", n, bus.wdata_MEM_WB, exp); end
                checks++; if (bus.num_write_MEM_WB !== num) begin errors++; $display("FAIL rnd_num[%0d]: got %0d expected %0d", n, bus.num_write_MEM_WB, num); end
                checks++; if (bus.reg_write_MEM_WB !== (rw && num != 5'd0)) begin errors++; $display("FAIL rnd_rw[%0d]: got %b expected %b", n, bus.reg_write_MEM_WB, rw && num != 5'd0); end
                checks++; if (bus.ins_MEM_WB !== ins) begin errors++; $display("FAIL rnd_ins[%0d]: got %h expected %h", n, bus.ins_MEM_WB, ins); end
            end
            checks++; if (bus.misalign_err !== ref_err) begin errors++; $display("FAIL rnd_err[%0d]: got %b expected %b", n, bus.misalign_err, ref_err); end
        end
        reset = 1'b0;
        bubble;
    endtask

    initial begin
        reset = 1'b1;
        bubble;
        repeat (2) tick;
        reset = 1'b0;
        preload;
        test_reset;
        test_back_to_back;
        test_select;
        test_zero_alias;
`ifdef BYTE_ACCESS_EN
        test_byte;
`endif
        test_misalign;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
